// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: oversamples the host serial link, decodes
// data/address/control commands, holds display RAM and shifts key data back.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sio_clk,
  input  logic         sio_stb,
  input  logic         sio_data_in,
  output logic         sio_data_out,
  output logic         sio_data_oe,
  input  logic [31:0]  keys,
  output logic [127:0] display_ram,
  output logic         display_on,
  output logic [2:0]   brightness,
  output logic         frame_done
);

  // state   | meaning
  // IDLE    | no frame open, waiting for strobe fall
  // CMD     | shifting in the command byte
  // WDATA   | shifting in display bytes after an address command
  // RDATA   | shifting key bytes out to the host
  // IGNORE  | frame open, remaining bits discarded
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, stb_sync_q, dat_sync_q;
  logic                   clk_prev_q, stb_prev_q;
  logic                   clk_s, stb_s, dat_s;
  logic                   clk_rise, clk_fall, stb_rise, stb_fall;

  state_t       state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   byte_q, byte_d;
  logic [7:0]   rx_byte;
  logic         mode_fixed_q, mode_fixed_d;
  logic [3:0]   ptr_q, ptr_d;
  logic [127:0] ram_q, ram_d;
  logic         on_q, on_d;
  logic [2:0]   bright_q, bright_d;
  logic [31:0]  key_sr_q, key_sr_d;
  logic [5:0]   rd_cnt_q, rd_cnt_d;
  logic         dout_q, dout_d;
  logic         doe_q, doe_d;
  logic         frame_done_q, frame_done_d;

  // Line idle levels are loaded at reset so no edge is seen on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      stb_sync_q <= '1;
      dat_sync_q <= '0;
      clk_prev_q <= 1'b1;
      stb_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sio_clk};
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], sio_stb};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], sio_data_in};
      clk_prev_q <= clk_s;
      stb_prev_q <= stb_s;
    end
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign dat_s    = dat_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s & clk_prev_q;
  assign stb_rise = stb_s & ~stb_prev_q;
  assign stb_fall = ~stb_s & stb_prev_q;
  assign rx_byte  = {dat_s, byte_q[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      byte_q       <= '0;
      mode_fixed_q <= 1'b0;
      ptr_q        <= '0;
      ram_q        <= '0;
      on_q         <= 1'b0;
      bright_q     <= '0;
      key_sr_q     <= '0;
      rd_cnt_q     <= '0;
      dout_q       <= 1'b0;
      doe_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_q       <= byte_d;
      mode_fixed_q <= mode_fixed_d;
      ptr_q        <= ptr_d;
      ram_q        <= ram_d;
      on_q         <= on_d;
      bright_q     <= bright_d;
      key_sr_q     <= key_sr_d;
      rd_cnt_q     <= rd_cnt_d;
      dout_q       <= dout_d;
      doe_q        <= doe_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_d       = byte_q;
    mode_fixed_d = mode_fixed_q;
    ptr_d        = ptr_q;
    ram_d        = ram_q;
    on_d         = on_q;
    bright_d     = bright_q;
    key_sr_d     = key_sr_q;
    rd_cnt_d     = rd_cnt_q;
    dout_d       = dout_q;
    doe_d        = doe_q;
    frame_done_d = 1'b0;

    if (stb_rise) begin
      state_d      = ST_IDLE;
      doe_d        = 1'b0;
      dout_d       = 1'b0;
      frame_done_d = 1'b1;
    end else if (stb_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = '0;
      doe_d     = 1'b0;
      dout_d    = 1'b0;
    end else begin
      case (state_q)
        ST_CMD: if (clk_rise) begin
          byte_d    = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (rx_byte[7:6])
              2'b01: begin
                mode_fixed_d = rx_byte[2];
                if (rx_byte[1]) begin
                  key_sr_d = keys;
                  rd_cnt_d = '0;
                  state_d  = ST_RDATA;
                end else begin
                  state_d = ST_IGNORE;
                end
              end
              2'b10: begin
                on_d     = rx_byte[3];
                bright_d = rx_byte[2:0];
                state_d  = ST_IGNORE;
              end
              2'b11: begin
                ptr_d   = rx_byte[3:0];
                state_d = ST_WDATA;
              end
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_WDATA: if (clk_rise) begin
          byte_d    = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ram_d[{ptr_q, 3'b000} +: 8] = rx_byte;
            if (!mode_fixed_q) ptr_d = ptr_q + 4'd1;
          end
        end
        // rd_cnt counts bits presented; 33 means the read is exhausted.
        ST_RDATA: if (clk_fall) begin
          if (rd_cnt_q == 6'd0) begin
            doe_d    = 1'b1;
            dout_d   = key_sr_q[0];
            rd_cnt_d = 6'd1;
          end else if (rd_cnt_q < 6'd32) begin
            key_sr_d = {1'b0, key_sr_q[31:1]};
            dout_d   = key_sr_q[1];
            rd_cnt_d = rd_cnt_q + 6'd1;
          end else if (rd_cnt_q == 6'd32) begin
            doe_d    = 1'b0;
            dout_d   = 1'b0;
            rd_cnt_d = 6'd33;
          end
        end
        default: ;
      endcase
    end
  end

  assign sio_data_out = dout_q;
  assign sio_data_oe  = doe_q;
  assign display_ram  = ram_q;
  assign display_on   = on_q;
  assign brightness   = bright_q;
  assign frame_done   = frame_done_q;

endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
- Synthesizable device-side model of the TM1638 LED/key driver chip: the responder end of the sio_clk/sio_stb/sio_data link driven by the board controller.
- Oversamples the three serial lines with the system clock and decodes data, address and display-control commands.
- Holds the 16-byte display RAM, display on/off and brightness state, and shifts 32 bits of key-scan data back on read commands.
- Used as a loopback peer in simulation and as an FPGA-side emulator; the top level merges sio_data_out/sio_data_oe into the bidirectional pin.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each sio input (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sio_clk  in  1  serial clock from host, idle high
- sio_stb  in  1  frame strobe from host, active low
- sio_data_in  in  1  serial data from host
- sio_data_out  out  1  serial data to host
- sio_data_oe  out  1  1 = responder drives the data pin
- keys  in  32  key-scan image; byte i = keys[8i+7:8i]
- display_ram  out  128  RAM byte a = display_ram[8a+7:8a], a = 0..15
- display_on  out  1  display enable from control command
- brightness  out  3  pulse-width setting from control command
- frame_done  out  1  one-cycle pulse when sio_stb rises

Behaviour:
- Reset values: display_ram 0, display_on 0, brightness 0, sio_data_out 0, sio_data_oe 0, frame_done 0. Mode register: write, auto-increment. Address pointer 0. FSM in IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected from one extra registered copy. Host sio_clk high and low phases must each last ≥ SYNC_STAGES+2 clk cycles.
- Bits are LSB first. Input bits are sampled on the detected sio_clk rising edge. Output bits change on the detected falling edge.
- FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
  - IDLE -> CMD on the sio_stb falling edge; bit counter cleared.
  - CMD, after 8 bits, decodes byte[7:6]:
    - 01 data command: bit1 = read, bit2 = fixed address. Updates the mode register. If read: capture keys into a 32-bit shift register and go to RDATA; else go to IGNORE.
    - 10 control command: display_on <= bit3, brightness <= bits[2:0]; go to IGNORE.
    - 11 address command: pointer <= bits[3:0]; go to WDATA.
    - 00: go to IGNORE.
  - WDATA: each completed byte is written to RAM[pointer] in the clk cycle the 8th rising edge is detected. The pointer then increments modulo 16 (0xF wraps to 0x0) unless in fixed mode.
  - RDATA: sio_data_oe = 1 and sio_data_out = shift[0] is presented on the detected falling edge after the command's 8th rising edge. Each later falling edge shifts right. After 32 bits, the next falling edge sets sio_data_oe = 0 and sio_data_out = 0; further clocks are ignored.
  - IGNORE: extra bits discarded.
- sio_stb rising in any state:
  - return to IDLE; sio_data_oe = 0 in the same cycle;
  - partial byte discarded; no RAM write;
  - frame_done pulses once.
- sio_stb falling while not in IDLE (glitch) restarts CMD.
- Async rst mid-frame returns everything to reset values immediately. The host frame is lost.
- Mode register persists across frames. The pointer persists only until the next address command.

Test Plan:
- Reset, then frame 0x8F -> display_on = 1, brightness = 7, frame_done = 1 for one cycle, RAM unchanged.
- Frame 0x40; frame 0xC0 then 16 bytes 0x00..0x0F -> display_ram byte a == a for all a. 17th byte 0xAA in the same frame wraps -> byte 0 = 0xAA.
- Frame 0x44; frame 0xC5, 0x11, 0x22, 0x33 (fixed mode) -> byte 5 = 0x33, bytes 6 and 7 unchanged.
- keys = 0x80402010, frame 0x42 followed by 32 host clocks -> host samples bytes 0x10, 0x20, 0x40, 0x80. sio_data_oe is high for exactly 32 bits and drops on the 33rd falling edge.
- Frame 0xC3, then 5 bits of 0x1F, then sio_stb raised -> byte 3 unchanged, FSM in IDLE, sio_data_oe = 0.
- rst asserted during the 20th read bit -> sio_data_oe = 0 asynchronously, display_ram = 0. A subsequent 0x8A frame sets display_on = 1, brightness = 2.
